// File: rtl/aes256_key_schedule_if.sv
// Key load handshake, status flags and round-key read port of the AES-256 key schedule.
// The slave modport is the key schedule; the master modport is the cipher/controller side.
interface aes256_key_schedule_if;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_rdata;

    modport slave (
        input  key_valid,
        input  key,
        input  rk_addr,
        output key_ready,
        output busy,
        output keys_valid,
        output rk_rdata
    );

    modport master (
        output key_valid,
        output key,
        output rk_addr,
        input  key_ready,
        input  busy,
        input  keys_valid,
        input  rk_rdata
    );
endinterface

// File: rtl/aes256_key_schedule.sv
// Sequential AES-256 key schedule: one round key per cycle, 15 keys held for an addressed read port.
// Latency: 13 cycles from key accept to keys_valid; read port 1 cycle (READ_REG=1) or 0.
// Backpressure: key_ready is low only while expanding; a key offered then waits, it is not queued.

module aes256_key_expansion_port (
    input  logic [3:0]   round_num,
    input  logic [255:0] key,
    output logic [127:0] new_key
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [31:0] w0, w1, w2, w3, w7;
    logic [31:0] t, n0, n1, n2, n3;
    logic [7:0]  rcon;

    always_comb begin
        w0   = key[255:224];
        w1   = key[223:192];
        w2   = key[191:160];
        w3   = key[159:128];
        w7   = key[31:0];
        rcon = 8'h01 << (round_num[3:1] - 3'd1);
        if (!round_num[0]) begin
            t = sub_word({w7[23:0], w7[31:24]}) ^ {rcon, 24'h000000};
        end else begin
            t = sub_word(w7);
        end
        n0      = w0 ^ t;
        n1      = w1 ^ n0;
        n2      = w2 ^ n1;
        n3      = w3 ^ n2;
        new_key = {n0, n1, n2, n3};
    end
endmodule

module aes256_key_schedule #(
    parameter bit READ_REG = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    aes256_key_schedule_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         accept;
    logic         last_round;
    logic [3:0]   cnt;
    logic [255:0] win;
    logic [127:0] new_key;
    logic [127:0] rd_dat;
    logic [127:0] rk [15];

    // win always holds the two most recent round keys, so storage is never read on the expand path.
    aes256_key_expansion_port u_port (
        .round_num (cnt),
        .key       (win),
        .new_key   (new_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.key_ready  = 1'b1;
        bus.busy       = 1'b0;
        bus.keys_valid = 1'b0;
        accept         = 1'b0;
        last_round     = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.key_valid;
                if (accept) state_nxt = EXPAND;
            end
            EXPAND: begin
                bus.key_ready = 1'b0;
                bus.busy      = 1'b1;
                last_round    = (cnt == 4'd14);
                if (last_round) state_nxt = DONE;
            end
            DONE: begin
                bus.keys_valid = 1'b1;
                accept         = bus.key_valid;
                if (accept) state_nxt = EXPAND;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
            win <= '0;
            for (int i = 0; i < 15; i++) begin
                rk[i] <= '0;
            end
        end else if (accept) begin
            rk[0] <= bus.key[255:128];
            rk[1] <= bus.key[127:0];
            win   <= bus.key;
            cnt   <= 4'd2;
        end else if (state == EXPAND) begin
            rk[cnt] <= new_key;
            win     <= {win[127:0], new_key};
            // Hold at 14 on the final round so the counter never leaves the storage range.
            if (!last_round) cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        rd_dat = '0;
        if (bus.rk_addr != 4'd15) rd_dat = rk[bus.rk_addr];
    end

    generate
        if (READ_REG) begin : g_rd_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bus.rk_rdata <= '0;
                end else begin
                    bus.rk_rdata <= rd_dat;
                end
            end
        end else begin : g_rd_comb
            always_comb bus.rk_rdata = rd_dat;
        end
    endgenerate
endmodule

// File: tb/tb_aes256_key_schedule.sv
// Scoreboarded bench: READ_REG=1 and READ_REG=0 instances share one stimulus stream;
// reads push expected keys, a monitor pops and compares, and also times keys_valid after each accept.
module tb_aes256_key_schedule;
    localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] RK_A [15] = '{
        128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
        128'ha573c29fa176c498a97fce93a572c09c, 128'h1651a8cd0244beda1a5da4c10640bade,
        128'hae87dff00ff11b68a68ed5fb03fc1567, 128'h6de1f1486fa54f9275f8eb5373b8518d,
        128'hc656827fc9a799176f294cec6cd5598b, 128'h3de23a75524775e727bf9eb45407cf39,
        128'h0bdc905fc27b0948ad5245a4c1871c2f, 128'h45f5a66017b2d387300d4d33640a820a,
        128'h7ccff71cbeb4fe5413e6bbf0d261a7df, 128'hf01afafee7a82979d7a5644ab3afe640,
        128'h2541fe719bf500258813bbd55a721c0a, 128'h4e5a6699a9f24fe07e572baacdf8cdea,
        128'h24fc79ccbf0979e9371ac23c6d68de36};

    localparam logic [127:0] RK_B [15] = '{
        128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
        128'h9ba354118e6925afa51a8b5f2067fcde, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
        128'hd59aecb85bf3c917fee94248de8ebe96, 128'hb5a9328a2678a647983122292f6c79b3,
        128'h812c81addadf48ba24360af2fab8b464, 128'h98c5bfc9bebd198e268c3ba709e04214,
        128'h68007bacb2df331696e939e46c518d80, 128'hc814e20476a9fb8a5025c02d59c58239,
        128'hde1369676ccc5a71fa2563959674ee15, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
        128'h749c47ab18501ddae2757e4f7401905a, 128'hcafaaae3e4d59b349adf6acebd10190d,
        128'hfe4890d1e6188d0b046df344706c631e};

    logic clk;
    logic rst_n;
    logic rd_req;
    logic req_d;
    int   cyc;
    int   acc_cyc;
    bit   kv_prev;
    int   checks;
    int   errors;
    logic [127:0] q_reg[$];
    logic [127:0] q_comb[$];

    aes256_key_schedule_if if1 ();
    aes256_key_schedule_if if0 ();

    assign if0.key_valid = if1.key_valid;
    assign if0.key       = if1.key;
    assign if0.rk_addr   = if1.rk_addr;

    aes256_key_schedule #(.READ_REG(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(if1));
    aes256_key_schedule #(.READ_REG(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor side: accept bookkeeping on the edge, comparisons on the falling edge.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        req_d <= rd_req;
        if (rst_n && if1.key_valid && if1.key_ready) acc_cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        logic [127:0] e;
        if (rd_req) begin
            if (q_comb.size() == 0) chk("q_comb_underflow", 128'd1, 128'd0);
            else begin
                e = q_comb.pop_front();
                chk("rd_comb", if0.rk_rdata, e);
            end
        end
        if (req_d) begin
            if (q_reg.size() == 0) chk("q_reg_underflow", 128'd1, 128'd0);
            else begin
                e = q_reg.pop_front();
                chk("rd_reg", if1.rk_rdata, e);
            end
        end
        if (if1.keys_valid && !kv_prev) chk("kv_latency", 128'(cyc - acc_cyc), 128'd13);
        kv_prev = if1.keys_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [127:0] e);
        if1.rk_addr = a;
        rd_req      = 1'b1;
        q_reg.push_back(e);
        q_comb.push_back(e);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic read_all(input int sel);
        for (int i = 0; i < 15; i++) begin
            rd(4'(i), (sel == 1) ? RK_A[i] : (sel == 2) ? RK_B[i] : 128'h0);
        end
        rd(4'd15, 128'h0);
        tick();
    endtask

    task automatic send_key(input logic [255:0] k);
        int n;
        n = 0;
        if1.key       = k;
        if1.key_valid = 1'b1;
        while (!if1.key_ready && n < 40) begin
            tick();
            n++;
        end
        chk("accept_timeout", 128'(if1.key_ready), 128'd1);
        tick();
        if1.key_valid = 1'b0;
    endtask

    task automatic wait_kv();
        int n;
        n = 0;
        while (!if1.keys_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("kv_timeout", 128'(if1.keys_valid), 128'd1);
        tick();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        acc_cyc       = 0;
        kv_prev       = 1'b0;
        rd_req        = 1'b0;
        rst_n         = 1'b0;
        if1.key_valid = 1'b0;
        if1.key       = '0;
        if1.rk_addr   = 4'd0;
        #3;
        chk("rst_busy", 128'(if1.busy), 128'd0);
        chk("rst_kv", 128'(if1.keys_valid), 128'd0);
        chk("rst_ready", 128'(if1.key_ready), 128'd1);
        chk("rst_rdata", if1.rk_rdata, 128'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // C.3 key from IDLE
        send_key(KEY_A);
        chk("t1_busy", 128'(if1.busy), 128'd1);
        chk("t1_kv", 128'(if1.keys_valid), 128'd0);
        wait_kv();
        read_all(1);

        // B offered in DONE, with a read of rk[5] on the edge that writes it
        send_key(KEY_B);
        chk("t3_kv_drop", 128'(if1.keys_valid), 128'd0);
        repeat (3) tick();
        rd(4'd5, RK_A[5]);
        rd(4'd5, RK_B[5]);
        wait_kv();
        read_all(2);

        // key_valid held through EXPAND: A accepted now, B only on the first DONE edge
        if1.key       = KEY_A;
        if1.key_valid = 1'b1;
        tick();
        if1.key = KEY_B;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("t2_ready_low", 128'(if1.key_ready), 128'd0);
        end
        @(negedge clk);
        chk("t2_ready_done", 128'(if1.key_ready), 128'd1);
        chk("t2_kv_done", 128'(if1.keys_valid), 128'd1);
        tick();
        if1.key_valid = 1'b0;
        chk("t2_busy2", 128'(if1.busy), 128'd1);
        chk("t2_kv2", 128'(if1.keys_valid), 128'd0);
        wait_kv();
        read_all(2);

        // asynchronous reset in the sixth EXPAND cycle
        send_key(KEY_A);
        if1.rk_addr = 4'd1;
        repeat (5) tick();
        chk("t4_pre_rdata", if1.rk_rdata, RK_A[1]);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_busy", 128'(if1.busy), 128'd0);
        chk("t4_kv", 128'(if1.keys_valid), 128'd0);
        chk("t4_rdata_reg", if1.rk_rdata, 128'h0);
        chk("t4_rdata_comb", if0.rk_rdata, 128'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        read_all(0);
        send_key(KEY_A);
        wait_kv();
        read_all(1);

        chk("q_reg_empty", 128'(q_reg.size()), 128'd0);
        chk("q_comb_empty", 128'(q_comb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
